// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and enables.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  // Current state is left visible by name so checkers can bind to it.
  state_t state;

  logic       op_known;
  logic [2:0] funct_alu;
  logic       funct_bad;
  logic       branch_ok;
  logic       pcupdate;
  logic       branch;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic       illegal_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECUTER;
            OP_ITYPE:          state <= EXECUTEI;
            OP_BRANCH:         state <= BRANCH;
            OP_JAL:            state <= JAL;
            default:           state <= FETCH;
          endcase
        end
        MEMADR:   state <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        JAL:      state <= ALUWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  immsrc = 2'b01;
      OP_BRANCH: immsrc = 2'b10;
      OP_JAL:    immsrc = 2'b11;
      default:   immsrc = 2'b00;
    endcase
  end

  // op[5] separates R-type from I-type, so addi never turns into a subtract.
  always_comb begin
    funct_alu = ALU_ADD;
    funct_bad = 1'b0;
    case (funct3)
      3'b000: funct_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111: funct_alu = 3'b010;
      3'b110: funct_alu = 3'b011;
      3'b100: funct_alu = 3'b100;
      3'b010: funct_alu = 3'b101;
      3'b001: funct_alu = 3'b110;
      3'b101: begin
        funct_alu = 3'b111;
        funct_bad = funct7b5;
      end
      default: begin
        funct_alu = ALU_ADD;
        funct_bad = 1'b1;
      end
    endcase
  end

  // Only beq and bne are implemented.
  assign branch_ok = (funct3[2:1] == 2'b00);

  always_comb begin
    irwrite_s  = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal_s  = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    case (state)
      FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
      end
      DECODE: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b01;
        illegal_s = ~op_known;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: adrsrc = 1'b1;
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTER: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b00;
        alucontrol = funct_alu;
        illegal_s  = funct_bad;
      end
      EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = funct_alu;
        illegal_s  = funct_bad;
      end
      ALUWB: regwrite_s = 1'b1;
      BRANCH: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b00;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        illegal_s  = ~branch_ok;
      end
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every write enable; the state is already FETCH for the selects.
  assign pcwrite  = ~reset & (pcupdate | (branch & branch_ok & (zero ^ funct3[0])));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;
  assign illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its
// state sequence and checks selects, enables and cycle counts.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .regwrite(regwrite), .immsrc(immsrc),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [3:0] st;
    reset = 1'b1; op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      st = dut.state;
      total++;
      if ({pcwrite, irwrite, regwrite, memwrite, illegal} !== 5'b0) begin
        bad++;
        $display("FAIL reset_enables[%0d] got=%b exp=00000", i,
                 {pcwrite, irwrite, regwrite, memwrite, illegal});
      end
      total++;
      if ({st, adrsrc, alusrca, alusrcb, resultsrc, alucontrol} !== {S_FETCH, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000}) begin
        bad++;
        $display("FAIL reset_selects[%0d] got=st%0d/%b%b%b%b%b exp=st0/0001010000", i, st,
                 adrsrc, alusrca, alusrcb, resultsrc, alucontrol);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    st = dut.state;
    total++;
    if ({st, irwrite, pcwrite} !== {S_FETCH, 2'b11}) begin
      bad++;
      $display("FAIL reset_release got=st%0d ir=%b pc=%b exp=st0 ir=1 pc=1", st, irwrite, pcwrite);
    end
    tick();
    st = dut.state;
    total++;
    if (st !== S_DECODE) begin
      bad++;
      $display("FAIL reset_first_decode got=%0d exp=%0d", st, S_DECODE);
    end
    for (int i = 0; i < 3; i++) tick();
    st = dut.state;
    total++;
    if (st !== S_FETCH) begin
      bad++;
      $display("FAIL reset_addi_return got=%0d exp=%0d", st, S_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5];
    logic [3:0] st;
    seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st = dut.state;
      total++;
      if (st !== seq[i]) begin
        bad++;
        $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, st, seq[i]);
      end
      total++;
      if ({regwrite, memwrite, illegal, adrsrc} !== {(i == 4), 1'b0, 1'b0, (i == 3)}) begin
        bad++;
        $display("FAIL lw_ctl[%0d] got=%b exp=%b", i, {regwrite, memwrite, illegal, adrsrc},
                 {(i == 4), 1'b0, 1'b0, (i == 3)});
      end
      if (i == 4) begin
        total++;
        if (resultsrc !== 2'b01) begin
          bad++;
          $display("FAIL lw_resultsrc got=%b exp=01", resultsrc);
        end
      end
      tick();
    end
    st = dut.state;
    total++;
    if (st !== S_FETCH) begin
      bad++;
      $display("FAIL lw_cycles got=%0d exp=%0d", st, S_FETCH);
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] v_op [7];
    logic [2:0] v_f3 [7];
    logic       v_f7 [7];
    logic [2:0] v_alu [7];
    logic       v_ill [7];
    logic [3:0] st;
    logic [3:0] ex_st;
    v_op  = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011};
    v_f3  = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b101, 3'b011, 3'b111};
    v_f7  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v_alu = '{3'b001, 3'b000, 3'b101, 3'b110, 3'b111, 3'b000, 3'b010};
    v_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      op = v_op[k]; funct3 = v_f3[k]; funct7b5 = v_f7[k];
      ex_st = v_op[k][5] ? S_EXECUTER : S_EXECUTEI;
      tick();
      tick();
      st = dut.state;
      total++;
      if ({st, alucontrol, illegal, alusrca} !== {ex_st, v_alu[k], v_ill[k], 2'b10}) begin
        bad++;
        $display("FAIL alu_exec[%0d] got=st%0d alu=%b ill=%b a=%b exp=st%0d alu=%b ill=%b a=10",
                 k, st, alucontrol, illegal, alusrca, ex_st, v_alu[k], v_ill[k]);
      end
      total++;
      if (alusrcb !== (v_op[k][5] ? 2'b00 : 2'b01)) begin
        bad++;
        $display("FAIL alu_srcb[%0d] got=%b exp=%b", k, alusrcb, v_op[k][5] ? 2'b00 : 2'b01);
      end
      tick();
      st = dut.state;
      total++;
      if ({st, regwrite, illegal, resultsrc} !== {S_ALUWB, 1'b1, 1'b0, 2'b00}) begin
        bad++;
        $display("FAIL alu_wb[%0d] got=st%0d rw=%b ill=%b rs=%b exp=st8 rw=1 ill=0 rs=00",
                 k, st, regwrite, illegal, resultsrc);
      end
      tick();
      st = dut.state;
      total++;
      if (st !== S_FETCH) begin
        bad++;
        $display("FAIL alu_cycles[%0d] got=%0d exp=%0d", k, st, S_FETCH);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] v_f3 [5];
    logic       v_z [5];
    logic       v_pc [5];
    logic       v_ill [5];
    logic [3:0] st;
    v_f3  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    v_z   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v_pc  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      op = 7'b1100011; funct3 = v_f3[k]; funct7b5 = 1'b0; zero = v_z[k];
      tick();
      total++;
      if ({pcwrite, immsrc} !== {1'b0, 2'b10}) begin
        bad++;
        $display("FAIL br_decode[%0d] got=pc%b imm%b exp=pc0 imm10", k, pcwrite, immsrc);
      end
      tick();
      st = dut.state;
      total++;
      if ({st, pcwrite, illegal, alucontrol} !== {S_BRANCH, v_pc[k], v_ill[k], 3'b001}) begin
        bad++;
        $display("FAIL br_exec[%0d] got=st%0d pc=%b ill=%b alu=%b exp=st9 pc=%b ill=%b alu=001",
                 k, st, pcwrite, illegal, alucontrol, v_pc[k], v_ill[k]);
      end
      tick();
      st = dut.state;
      total++;
      if (st !== S_FETCH) begin
        bad++;
        $display("FAIL br_cycles[%0d] got=%0d exp=%0d", k, st, S_FETCH);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [3:0] st;
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    tick();
    total++;
    if ({immsrc, alusrca, alusrcb} !== {2'b11, 2'b01, 2'b01}) begin
      bad++;
      $display("FAIL jal_decode got=imm%b a%b b%b exp=imm11 a01 b01", immsrc, alusrca, alusrcb);
    end
    tick();
    st = dut.state;
    total++;
    if ({st, alusrca, alusrcb, pcwrite, regwrite} !== {S_JAL, 2'b01, 2'b10, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL jal_state got=st%0d a%b b%b pc%b rw%b exp=st10 a01 b10 pc1 rw0",
               st, alusrca, alusrcb, pcwrite, regwrite);
    end
    tick();
    st = dut.state;
    total++;
    if ({st, regwrite, pcwrite} !== {S_ALUWB, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL jal_wb got=st%0d rw%b pc%b exp=st8 rw1 pc0", st, regwrite, pcwrite);
    end
    tick();
    st = dut.state;
    total++;
    if (st !== S_FETCH) begin
      bad++;
      $display("FAIL jal_cycles got=%0d exp=%0d", st, S_FETCH);
    end
  endtask

  task automatic test_illegal_op();
    logic [3:0] st;
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
    total++;
    if (illegal !== 1'b0) begin
      bad++;
      $display("FAIL illop_fetch got=%b exp=0", illegal);
    end
    tick();
    st = dut.state;
    total++;
    if ({st, illegal, pcwrite, irwrite, regwrite, memwrite} !== {S_DECODE, 5'b10000}) begin
      bad++;
      $display("FAIL illop_decode got=st%0d ill%b en%b exp=st1 ill1 en0000", st, illegal,
               {pcwrite, irwrite, regwrite, memwrite});
    end
    tick();
    st = dut.state;
    total++;
    if ({st, illegal} !== {S_FETCH, 1'b0}) begin
      bad++;
      $display("FAIL illop_return got=st%0d ill%b exp=st0 ill0", st, illegal);
    end
  endtask

  task automatic test_reset_in_sw();
    logic [3:0] st;
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    tick();
    total++;
    if (immsrc !== 2'b01) begin
      bad++;
      $display("FAIL sw_immsrc got=%b exp=01", immsrc);
    end
    tick();
    tick();
    st = dut.state;
    total++;
    if ({st, memwrite, adrsrc} !== {S_MEMWRITE, 2'b11}) begin
      bad++;
      $display("FAIL sw_memwrite got=st%0d mw%b adr%b exp=st5 mw1 adr1", st, memwrite, adrsrc);
    end
    reset = 1'b1;
    #1;
    st = dut.state;
    total++;
    if ({st, memwrite, adrsrc, pcwrite, irwrite} !== {S_FETCH, 4'b0000}) begin
      bad++;
      $display("FAIL sw_abort got=st%0d mw%b adr%b pc%b ir%b exp=st0 all0", st, memwrite, adrsrc,
               pcwrite, irwrite);
    end
    tick();
    st = dut.state;
    total++;
    if ({st, pcwrite, irwrite, regwrite, memwrite} !== {S_FETCH, 4'b0000}) begin
      bad++;
      $display("FAIL sw_held got=st%0d en%b exp=st0 en0000", st,
               {pcwrite, irwrite, regwrite, memwrite});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({irwrite, pcwrite} !== 2'b11) begin
      bad++;
      $display("FAIL sw_restart got=ir%b pc%b exp=ir1 pc1", irwrite, pcwrite);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu_decode();
    test_branch();
    test_jal();
    test_illegal_op();
    test_reset_in_sw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
